// File: rtl/key_tamper_monitor.sv
// Tamper monitor on the DES key path: compares the delivered key against the golden key,
// tracks suspect/alarm episodes, and forwards a registered key. Optional macro: KEY_TAMPER_CORRECT_EN.
module key_tamper_monitor #(
  parameter int unsigned ALARM_THRESH = 3,
  parameter int unsigned CLEAN_THRESH = 4,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  input  logic [55:0]      key_ref,
  input  logic [55:0]      key_obs,
  input  logic [1:32]      trigger,
  input  logic             clear,
  output logic [55:0]      key_out,
  output logic             key_out_valid,
  output logic             alarm,
  output logic             suspect,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [5:0]       diff_bits,
  output logic [1:32]      trig_log
);

  typedef enum logic [1:0] {StMonitor, StSuspect, StAlarm} state_e;

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] clean_q, clean_d, clean_inc;
  logic [1:32]      trig_q, trig_d;
  logic [55:0]      key_q, key_d;
  logic             kov_q;
  logic [5:0]       diff_q, diff_d;
  logic             mism;
  logic             use_ref;

  function automatic logic [5:0] popcount56(input logic [55:0] x);
    logic [5:0] s;
    s = '0;
    for (int i = 0; i < 56; i++) begin
      s = s + 6'(x[i]);
    end
    return s;
  endfunction

  assign mism      = key_valid && (key_ref != key_obs);
  assign cnt_inc   = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
  assign clean_inc = (clean_q == CntMax) ? clean_q : clean_q + 1'b1;

`ifdef KEY_TAMPER_CORRECT_EN
  // Substitute the golden key whenever the delivered one cannot be trusted.
  assign use_ref = mism || (key_valid && (state_q == StAlarm));
`else
  assign use_ref = 1'b0;
`endif

  // Key forwarding path; independent of clear.
  always_comb begin
    key_d  = key_q;
    diff_d = diff_q;
    if (key_valid) begin
      key_d  = use_ref ? key_ref : key_obs;
      diff_d = popcount56(key_ref ^ key_obs);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clean_d = clean_q;
    trig_d  = trig_q;
    if (clear) begin
      state_d = StMonitor;
      cnt_d   = '0;
      clean_d = '0;
      trig_d  = '0;
    end else begin
      unique case (state_q)
        StMonitor: begin
          if (mism) begin
            cnt_d   = CNT_W'(1);
            clean_d = '0;
            trig_d  = trigger;
            state_d = (ALARM_THRESH == 1) ? StAlarm : StSuspect;
          end
        end
        StSuspect: begin
          if (mism) begin
            cnt_d   = cnt_inc;
            clean_d = '0;
            if (32'(cnt_inc) >= ALARM_THRESH) state_d = StAlarm;
          end else if (key_valid) begin
            clean_d = clean_inc;
            if (32'(clean_inc) >= CLEAN_THRESH) begin
              state_d = StMonitor;
              cnt_d   = '0;
              clean_d = '0;
            end
          end
        end
        StAlarm: begin
          if (mism) cnt_d = cnt_inc;
        end
        default: state_d = StMonitor;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StMonitor;
      cnt_q   <= '0;
      clean_q <= '0;
      trig_q  <= '0;
      key_q   <= '0;
      kov_q   <= 1'b0;
      diff_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      trig_q  <= trig_d;
      key_q   <= key_d;
      kov_q   <= key_valid;
      diff_q  <= diff_d;
    end
  end

  assign key_out       = key_q;
  assign key_out_valid = kov_q;
  assign alarm         = (state_q == StAlarm);
  assign suspect       = (state_q == StSuspect);
  assign mismatch_cnt  = cnt_q;
  assign diff_bits     = diff_q;
  assign trig_log      = trig_q;

endmodule

// File: tb/tb_key_tamper_monitor.sv
// Table-driven directed bench for key_tamper_monitor, plus a hand-written async reset sequence.
module tb_key_tamper_monitor;

`ifdef KEY_TAMPER_CORRECT_EN
  localparam bit Corr = 1'b1;
`else
  localparam bit Corr = 1'b0;
`endif

  localparam logic [55:0] K  = 56'h0123456789ABCD;
  localparam logic [55:0] X1 = K ^ 56'h1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic [55:0] key_ref = '0;
  logic [55:0] key_obs = '0;
  logic [1:32] trigger = '0;
  logic        clear = 1'b0;
  logic [55:0] key_out;
  logic        key_out_valid;
  logic        alarm;
  logic        suspect;
  logic [7:0]  mismatch_cnt;
  logic [5:0]  diff_bits;
  logic [1:32] trig_log;

  key_tamper_monitor #(
    .ALARM_THRESH(3),
    .CLEAN_THRESH(4),
    .CNT_W       (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_valid    (key_valid),
    .key_ref      (key_ref),
    .key_obs      (key_obs),
    .trigger      (trigger),
    .clear        (clear),
    .key_out      (key_out),
    .key_out_valid(key_out_valid),
    .alarm        (alarm),
    .suspect      (suspect),
    .mismatch_cnt (mismatch_cnt),
    .diff_bits    (diff_bits),
    .trig_log     (trig_log)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [55:0] r;
    logic [55:0] o;
    logic [31:0] t;
    logic        c;
    logic        e_al;
    logic        e_su;
    logic [7:0]  e_cnt;
    logic [5:0]  e_diff;
    logic        e_kov;
    logic [55:0] e_key;
    logic [31:0] e_trig;
  } vec_t;

  vec_t vecs[$];
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic logic [55:0] ko(input logic sel, input logic [55:0] r, input logic [55:0] o);
    return (Corr && sel) ? r : o;
  endfunction

  task automatic add(input logic v, input logic [55:0] r, input logic [55:0] o,
                     input logic [31:0] t, input logic c, input logic al, input logic su,
                     input logic [7:0] cnt, input logic [5:0] diff, input logic kov,
                     input logic [55:0] key, input logic [31:0] trig);
    vec_t x;
    x = '{v: v, r: r, o: o, t: t, c: c, e_al: al, e_su: su, e_cnt: cnt, e_diff: diff,
          e_kov: kov, e_key: key, e_trig: trig};
    vecs.push_back(x);
  endtask

  task automatic chk(input string name, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec=%0d got=%h want=%h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic al, input logic su, input logic [7:0] cnt,
                         input logic [5:0] diff, input logic kov, input logic [55:0] key,
                         input logic [31:0] trig);
    chk("alarm", idx, 64'(alarm), 64'(al));
    chk("suspect", idx, 64'(suspect), 64'(su));
    chk("mismatch_cnt", idx, 64'(mismatch_cnt), 64'(cnt));
    chk("diff_bits", idx, 64'(diff_bits), 64'(diff));
    chk("key_out_valid", idx, 64'(key_out_valid), 64'(kov));
    chk("key_out", idx, 64'(key_out), 64'(key));
    chk("trig_log", idx, 64'(trig_log), 64'(trig));
  endtask

  initial begin
    logic [55:0] xa;
    logic [55:0] xf;
    xa = K ^ 56'hFF_FFFF_FFFF_FFFF;
    xf = K ^ 56'hF0;

    // Clean traffic
    for (int i = 0; i < 10; i++) add(1, K, K, 0, 0, 0, 0, 0, 0, 1, K, 0);
    // Single mismatch then recovery after four matches
    add(1, K, X1, 32'hF, 0, 0, 1, 1, 1, 1, ko(1, K, X1), 32'hF);
    for (int i = 0; i < 3; i++) add(1, K, K, 0, 0, 0, 1, 1, 0, 1, K, 32'hF);
    add(1, K, K, 0, 0, 0, 0, 0, 0, 1, K, 32'hF);
    // Mismatch, match, match, (idle), mismatch, mismatch -> alarm with count 3
    add(1, K, X1, 32'hA5, 0, 0, 1, 1, 1, 1, ko(1, K, X1), 32'hA5);
    add(1, K, K, 0, 0, 0, 1, 1, 0, 1, K, 32'hA5);
    add(1, K, K, 0, 0, 0, 1, 1, 0, 1, K, 32'hA5);
    add(0, K, X1, 0, 0, 0, 1, 1, 0, 0, K, 32'hA5);
    add(1, K, X1, 0, 0, 0, 1, 2, 1, 1, ko(1, K, X1), 32'hA5);
    add(1, K, X1, 0, 0, 1, 0, 3, 1, 1, ko(1, K, X1), 32'hA5);
    add(1, K, K, 0, 0, 1, 0, 3, 0, 1, K, 32'hA5);
    add(1, K, xf, 0, 0, 1, 0, 4, 4, 1, ko(1, K, xf), 32'hA5);
    // Clear wins over a simultaneous mismatch; key still forwarded
    add(1, K, X1, 32'h99, 1, 0, 0, 0, 1, 1, ko(1, K, X1), 0);
    add(1, K, K, 0, 0, 0, 0, 0, 0, 1, K, 0);
    // Three consecutive mismatches with differing popcounts, then sticky alarm
    add(1, K, xa, 32'h3C, 0, 0, 1, 1, 56, 1, ko(1, K, xa), 32'h3C);
    add(1, K, xf, 0, 0, 0, 1, 2, 4, 1, ko(1, K, xf), 32'h3C);
    add(1, K, X1, 0, 0, 1, 0, 3, 1, 1, ko(1, K, X1), 32'h3C);
    for (int i = 0; i < 20; i++) add(1, K, K, 0, 0, 1, 0, 3, 0, 1, K, 32'h3C);
    // Clear without a key sample: outputs of the key path hold
    add(0, K, X1, 0, 1, 0, 0, 0, 0, 0, K, 0);
    // Reach SUSPECT with count 2 for the async reset sequence
    add(1, K, X1, 32'h77, 0, 0, 1, 1, 1, 1, ko(1, K, X1), 32'h77);
    add(1, K, X1, 0, 0, 0, 1, 2, 1, 1, ko(1, K, X1), 32'h77);

    #12;
    chk_all(-1, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      key_valid = vecs[i].v;
      key_ref   = vecs[i].r;
      key_obs   = vecs[i].o;
      trigger   = vecs[i].t;
      clear     = vecs[i].c;
      @(posedge clk);
      #1;
      chk_all(i, vecs[i].e_al, vecs[i].e_su, vecs[i].e_cnt, vecs[i].e_diff, vecs[i].e_kov,
              vecs[i].e_key, vecs[i].e_trig);
    end

    // Asynchronous reset mid-cycle from SUSPECT: outputs clear before any clock edge
    #3;
    rst_n = 1'b0;
    #1;
    chk_all(1000, 0, 0, 0, 0, 0, 0, 0);
    #3;
    rst_n = 1'b1;
    key_valid = 1'b1;
    key_ref   = K;
    key_obs   = K;
    trigger   = '0;
    clear     = 1'b0;
    @(posedge clk);
    #1;
    chk_all(1001, 0, 0, 0, 0, 1, K, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/key_tamper_monitor.md
Name: key_tamper_monitor

Overview:
- Sits on the receiving end of the 56-bit DES key path, between the key source and the DES core.
- Compares the key actually delivered (possibly trojan-modified) against the golden key registered at the source.
- Counts and characterises mismatches, logs the trigger bus value at the first tamper event, and raises a sticky alarm.
- Forwards a registered key to the core; optionally substitutes the golden key when tampering is detected.

Parameters:
- ALARM_THRESH, 3, mismatching samples within one suspect episode needed to enter ALARM (legal 1..2^CNT_W-1).
- CLEAN_THRESH, 4, consecutive matching samples in SUSPECT needed to return to MONITOR (legal >=1).
- CNT_W, 8, width of mismatch_cnt and the internal clean counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- key_valid  input  1  key_ref/key_obs/trigger are valid this cycle.
- key_ref  input  56  golden key from key source.
- key_obs  input  56  key as received at DES core input.
- trigger  input  [1:32]  trigger bus sampled alongside the key.
- clear  input  1  synchronous clear of alarm, counters and log.
- key_out  output  56  registered key to DES core.
- key_out_valid  output  1  key_out valid.
- alarm  output  1  sticky tamper alarm.
- suspect  output  1  high while FSM is in SUSPECT.
- mismatch_cnt  output  CNT_W  mismatches in current episode, saturating.
- diff_bits  output  6  popcount of (key_ref XOR key_obs) for the last valid sample (0..56).
- trig_log  output  [1:32]  trigger value captured at first mismatch of the episode.

Behaviour:
- Reset (async, rst_n=0): state=MONITOR; key_out=0; key_out_valid=0; alarm=0; suspect=0; mismatch_cnt=0; diff_bits=0; trig_log=0; clean counter=0. All take effect immediately, including mid-episode.
- Latency:
  - key_out, key_out_valid, diff_bits and state/flag updates appear 1 cycle after the key_valid sample.
  - key_out_valid is key_valid delayed by 1 cycle.
  - key_out and diff_bits hold their values when key_valid=0.
- mism = key_valid & (key_ref != key_obs), evaluated combinationally; everything downstream is registered.
- FSM transitions:
  - MONITOR:
    - mism -> mismatch_cnt=1; trig_log<=trigger; clean=0.
    - If ALARM_THRESH==1 -> ALARM, else -> SUSPECT.
    - Matching samples leave the state unchanged.
  - SUSPECT:
    - mism -> mismatch_cnt+1 (saturating); clean=0. If the new count >= ALARM_THRESH -> ALARM.
    - Valid match -> clean+1. If clean reaches CLEAN_THRESH -> MONITOR; mismatch_cnt=0; trig_log retained.
    - key_valid=0 -> no change.
  - ALARM:
    - Sticky; alarm=1. mismatch_cnt keeps counting mismatches (saturating at 2^CNT_W-1).
    - Leaves only on clear or reset.
- clear (synchronous): state=MONITOR; alarm=0; mismatch_cnt=0; clean=0; trig_log=0.
  - clear wins over a simultaneous key_valid sample: no FSM or counter update from that sample.
  - The key is still forwarded (key_out/key_out_valid/diff_bits update normally).
- alarm=1 exactly when state==ALARM; suspect=1 exactly when state==SUSPECT.
- Counter wrap is forbidden; all counters saturate.

Optional Feature:
- Macro: KEY_TAMPER_CORRECT_EN.
- Defined: key_out <= key_ref on any mism sample, and on every valid sample while in ALARM; otherwise key_out <= key_obs. Active correction.
- Undefined: key_out <= key_obs always; the block is monitor-only and detection behaviour is identical.

Test Plan:
- Reset then 10 valid samples with key_ref=key_obs=56'h0123456789ABCD -> alarm=0, suspect=0, mismatch_cnt=0, diff_bits=0; key_out=56'h0123456789ABCD one cycle after each sample.
- Single mismatch (key_obs=key_ref^56'h1, trigger=32'h0000000F) then 4 matches -> suspect=1, mismatch_cnt=1, diff_bits=1, trig_log=32'h0000000F; after the 4th match suspect=0, mismatch_cnt=0.
- 3 consecutive mismatches, key_obs=key_ref^56'h1 -> alarm=1 one cycle after the 3rd; alarm stays 1 through 20 subsequent matching samples. With KEY_TAMPER_CORRECT_EN, key_out=key_ref on all of them; without, key_out=key_obs.
- Mismatch, match, match, mismatch, mismatch (clean count reset) -> ALARM after the 5th sample, mismatch_cnt=3.
- In ALARM, assert clear in the same cycle as a mismatching key_valid -> next cycle alarm=0, mismatch_cnt=0, trig_log=0, state MONITOR, key_out_valid=1.
- In SUSPECT with mismatch_cnt=2, pulse rst_n low mid-cycle -> all outputs 0 immediately, without waiting for a clock edge.
